// File: rtl/xalu_pkg.sv
// Shared encodings for the multiply/divide unit: Start and XAluOp codes,
// default latencies and FSM state type, also used by the instruction decoder.
package xalu_pkg;

  localparam logic [1:0] START_NONE   = 2'd0;
  localparam logic [1:0] START_LAUNCH = 2'd1;
  localparam logic [1:0] START_MOVE   = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_mdu_op(input logic [2:0] op);
    logic res;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed combinationally from latched operands and committed on the last busy edge.
module xalu
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Start,
  input  logic [2:0]  XAluOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]         op_q, op_d;
  logic               busy_q, busy_d;

  logic [63:0] smul_s, umul_s;
  logic [31:0] div_b_s, uquo_s, urem_s, abs_a_s, abs_b_s, mquo_s, mrem_s, squo_s, srem_s;

  // Product/quotient datapath on latched operands; a zero divisor is steered to 1 to keep it defined.
  always_comb begin
    smul_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    umul_s  = {32'd0, a_q} * {32'd0, b_q};
    div_b_s = (b_q == 32'd0) ? 32'd1 : b_q;
    uquo_s  = a_q / div_b_s;
    urem_s  = a_q % div_b_s;
    abs_a_s = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b_s = div_b_s[31] ? (32'd0 - div_b_s) : div_b_s;
    mquo_s  = abs_a_s / abs_b_s;
    mrem_s  = abs_a_s % abs_b_s;
    squo_s  = (a_q[31] ^ b_q[31]) ? (32'd0 - mquo_s) : mquo_s;
    srem_s  = a_q[31] ? (32'd0 - mrem_s) : mrem_s;
  end

  // Next-state logic: launch/move in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if ((Start == START_LAUNCH) && is_mdu_op(XAluOp)) begin
          a_d     = A;
          b_d     = B;
          op_d    = XAluOp;
          state_d = ST_RUN;
          if ((XAluOp == OP_MULT) || (XAluOp == OP_MULTU)) begin
            cnt_d = CNT_W'(MULT_CYCLES);
          end else begin
            cnt_d = CNT_W'(DIV_CYCLES);
          end
        end else if ((Start == START_MOVE) && (XAluOp == OP_MTHI)) begin
          hi_d = A;
        end else if ((Start == START_MOVE) && (XAluOp == OP_MTLO)) begin
          lo_d = A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = smul_s;
            OP_MULTU: {hi_d, lo_d} = umul_s;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = squo_s;
                hi_d = srem_s;
              end else begin
                lo_d = lo_q;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = uquo_s;
                hi_d = urem_s;
              end else begin
                lo_d = lo_q;
              end
            end
            default: lo_d = lo_q;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State, operand and HI/LO registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_W'(0);
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Directed self-checking bench for xalu: latency, results, HI/LO hold,
// ignored commands and asynchronous reset abort.
module tb_xalu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Start = 2'd0;
  logic [2:0]  XAluOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  xalu dut (
    .clk(clk), .reset(reset), .Start(Start), .XAluOp(XAluOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Launch at a negedge, scramble operands after the launch edge, optionally
  // fire ignored commands during RUN, and check Busy/HI/LO every cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input bit noisy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    Start = 2'd1; XAluOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 2'd0; A = 32'hDEAD_BEEF; B = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq({tag, " busy"}, {31'd0, Busy}, 32'd1);
      check_eq({tag, " hold hi"}, HI, model_hi);
      check_eq({tag, " hold lo"}, LO, model_lo);
      if (noisy) begin
        Start  = (i % 2 == 0) ? 2'd2 : 2'd1;
        XAluOp = (i % 2 == 0) ? 3'd5 : 3'd0;
        A = 32'h0000_0001; B = 32'h0000_0003;
      end
    end
    @(posedge clk);
    #1;
    Start = 2'd0; XAluOp = 3'd7;
    @(negedge clk);
    check_eq({tag, " done busy"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, " hi"}, HI, exp_hi);
    check_eq({tag, " lo"}, LO, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  // One-cycle command issued in IDLE; expect the given HI/LO one edge later, no Busy.
  task automatic do_cmd(input string tag, input logic [1:0] st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    Start = st; XAluOp = op; A = a; B = 32'h0000_0005;
    @(posedge clk);
    #1;
    Start = 2'd0;
    @(negedge clk);
    check_eq({tag, " busy"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, " hi"}, HI, exp_hi);
    check_eq({tag, " lo"}, LO, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    #3;
    check_eq("reset busy", {31'd0, Busy}, 32'd0);
    check_eq("reset hi", HI, 32'd0);
    check_eq("reset lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu by0", 3'd3, 32'd7, 32'd0, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 10, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("mult neg", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5, 1'b0, 32'h0000_0000, 32'h0000_000F);

    do_cmd("mthi", 2'd2, 3'd4, 32'h1234_5678, 32'h1234_5678, 32'h0000_000F);
    do_cmd("mtlo", 2'd2, 3'd5, 32'hCAFE_0001, 32'h1234_5678, 32'hCAFE_0001);
    do_cmd("launch op4", 2'd1, 3'd4, 32'h5555_5555, 32'h1234_5678, 32'hCAFE_0001);
    do_cmd("move op0", 2'd2, 3'd0, 32'h6666_6666, 32'h1234_5678, 32'hCAFE_0001);
    do_cmd("move op6", 2'd2, 3'd6, 32'h7777_7777, 32'h1234_5678, 32'hCAFE_0001);

    // Asynchronous reset in the 4th busy cycle of a div.
    @(negedge clk);
    Start = 2'd1; XAluOp = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1;
    Start = 2'd0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre-reset busy", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("abort busy", {31'd0, Busy}, 32'd0);
    check_eq("abort hi", HI, 32'd0);
    check_eq("abort lo", LO, 32'd0);
    #2;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("after abort busy", {31'd0, Busy}, 32'd0);
    check_eq("after abort hi", HI, 32'd0);
    check_eq("after abort lo", LO, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    run_op("post-reset mult", 3'd0, 32'd3, 32'd4, 5, 1'b0, 32'h0000_0000, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
